// File: rtl/vending_machine_multi_pkg.sv
// Shared types and coin helpers for the multi-product vending machine.
// Credit is counted in 5-rupee units throughout.
package vm_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10,
    COIN_20   = 2'b11
  } coin_t;

  typedef enum logic [1:0] {
    IDLE,
    CREDIT,
    VEND,
    CHANGE
  } state_t;

  function automatic logic [2:0] coin_units(input coin_t c);
    case (c)
      COIN_5:  return 3'd1;
      COIN_10: return 3'd2;
      COIN_20: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Greedy change: largest coin not exceeding the remaining credit.
  function automatic coin_t units_to_coin(input int units);
    if (units >= 4)      return COIN_20;
    else if (units >= 2) return COIN_10;
    else                 return COIN_5;
  endfunction

endpackage

// File: rtl/vending_machine_multi_stock_bank.sv
// Per-item stock counters with refill/vend arbitration and sold-out decode.
module vm_stock_bank #(
  parameter int NUM_ITEMS  = 4,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dec_valid,
  input  logic [$clog2(NUM_ITEMS)-1:0] dec_item,
  input  logic                         refill_valid,
  input  logic [$clog2(NUM_ITEMS)-1:0] refill_item,
  output logic [NUM_ITEMS-1:0]         sold_out
);

  localparam int ITEM_W = $clog2(NUM_ITEMS);
  localparam logic [STOCK_W-1:0] STOCK_MAX = '1;

  for (genvar i = 0; i < NUM_ITEMS; i++) begin : gen_item
    logic [STOCK_W-1:0] stock_q;
    logic               inc;
    logic               dec;

    // Out-of-range refill indices never match any counter, so they are dropped.
    assign inc = refill_valid && (refill_item == ITEM_W'(i));
    assign dec = dec_valid && (dec_item == ITEM_W'(i));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        stock_q <= STOCK_W'(INIT_STOCK);
      end else if (inc && !dec) begin
        if (stock_q != STOCK_MAX) stock_q <= stock_q + STOCK_W'(1);
      end else if (dec && !inc) begin
        if (stock_q != '0) stock_q <= stock_q - STOCK_W'(1);
      end
    end

    assign sold_out[i] = (stock_q == '0);
  end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending machine: coin credit, per-item pricing and stock,
// one-cycle vend and greedy one-coin-per-cycle change return.
module vending_machine_multi #(
  parameter int                            NUM_ITEMS  = 4,
  parameter int                            CREDIT_W   = 5,
  parameter int                            MAX_CREDIT = 20,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES     = {5'd6, 5'd5, 5'd4, 5'd3},
  parameter int                            STOCK_W    = 4,
  parameter int                            INIT_STOCK = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   coin,
  input  logic                         sel_valid,
  input  logic [$clog2(NUM_ITEMS)-1:0] sel_item,
  input  logic                         cancel,
  input  logic                         refill_valid,
  input  logic [$clog2(NUM_ITEMS)-1:0] refill_item,
  output logic                         despatch,
  output logic [$clog2(NUM_ITEMS)-1:0] despatch_item,
  output logic                         sel_nack,
  output logic                         coin_reject,
  output logic                         change_valid,
  output logic [1:0]                   change_coin,
  output logic [CREDIT_W-1:0]          credit,
  output logic [NUM_ITEMS-1:0]         sold_out,
  output logic                         busy
);

  import vm_pkg::*;

  localparam int ITEM_W = $clog2(NUM_ITEMS);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [ITEM_W-1:0]   item_q, item_d;
  logic                despatch_d, nack_d, reject_d, dec_valid;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] coin_val, eff, price_sel, price_item, change_units;
  logic                coin_ok, sel_in_range, sel_empty;

  function automatic logic [CREDIT_W-1:0] price_of(input logic [ITEM_W-1:0] idx);
    price_of = '0;
    for (int i = 0; i < NUM_ITEMS; i++)
      if (idx == ITEM_W'(i)) price_of = PRICES[i*CREDIT_W +: CREDIT_W];
  endfunction

  vm_stock_bank #(
    .NUM_ITEMS  (NUM_ITEMS),
    .STOCK_W    (STOCK_W),
    .INIT_STOCK (INIT_STOCK)
  ) u_stock (
    .clk          (clk),
    .rst          (rst),
    .dec_valid    (dec_valid),
    .dec_item     (item_q),
    .refill_valid (refill_valid),
    .refill_item  (refill_item),
    .sold_out     (sold_out)
  );

  always_comb begin
    sel_empty = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++)
      if (sel_item == ITEM_W'(i)) sel_empty = sold_out[i];
  end

  assign sel_in_range = ({1'b0, sel_item} < (ITEM_W+1)'(NUM_ITEMS));

  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    item_d       = item_q;
    despatch_d   = 1'b0;
    nack_d       = 1'b0;
    reject_d     = 1'b0;
    dec_valid    = 1'b0;
    coin_val     = CREDIT_W'(coin_units(coin_t'(coin)));
    // One extra bit so an over-cap sum cannot wrap past the comparison.
    sum          = {1'b0, credit_q} + {1'b0, coin_val};
    coin_ok      = (coin != 2'b00) && (sum <= (CREDIT_W+1)'(MAX_CREDIT));
    eff          = coin_ok ? sum[CREDIT_W-1:0] : credit_q;
    price_sel    = price_of(sel_item);
    price_item   = price_of(item_q);
    change_units = CREDIT_W'(coin_units(units_to_coin(int'(credit_q))));

    case (state_q)
      IDLE, CREDIT: begin
        if (cancel && state_q == CREDIT) begin
          state_d  = CHANGE;
          reject_d = (coin != 2'b00);
        end else begin
          reject_d = (coin != 2'b00) && !coin_ok;
          credit_d = eff;
          state_d  = (eff != '0) ? CREDIT : IDLE;
          if (sel_valid) begin
            if (!sel_in_range || sel_empty || eff < price_sel) begin
              nack_d = 1'b1;
            end else begin
              state_d    = VEND;
              item_d     = sel_item;
              despatch_d = 1'b1;
            end
          end
        end
      end
      VEND: begin
        reject_d  = (coin != 2'b00);
        dec_valid = 1'b1;
        credit_d  = credit_q - price_item;
        state_d   = (credit_d != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        reject_d = (coin != 2'b00);
        credit_d = credit_q - change_units;
        state_d  = (credit_d == '0) ? IDLE : CHANGE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      item_q        <= '0;
      despatch      <= 1'b0;
      despatch_item <= '0;
      sel_nack      <= 1'b0;
      coin_reject   <= 1'b0;
      change_valid  <= 1'b0;
      change_coin   <= 2'b00;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      item_q        <= item_d;
      despatch      <= despatch_d;
      despatch_item <= item_d;
      sel_nack      <= nack_d;
      coin_reject   <= reject_d;
      change_valid  <= (state_d == CHANGE);
      change_coin   <= (state_d == CHANGE) ? units_to_coin(int'(credit_d)) : COIN_NONE;
      busy          <= (state_d == VEND) || (state_d == CHANGE);
    end
  end

  assign credit = credit_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed bench for vending_machine_multi with a despatch/change scoreboard.
module tb_vending_machine_multi;

  logic       clk;
  logic       rst;
  logic [1:0] coin;
  logic       sel_valid;
  logic [1:0] sel_item;
  logic       cancel;
  logic       refill_valid;
  logic [1:0] refill_item;
  logic       despatch;
  logic [1:0] despatch_item;
  logic       sel_nack;
  logic       coin_reject;
  logic       change_valid;
  logic [1:0] change_coin;
  logic [4:0] credit;
  logic [3:0] sold_out;
  logic       busy;

  int tests = 0;
  int fails = 0;
  logic [1:0] exp_desp[$];
  logic [1:0] exp_change[$];

  vending_machine_multi dut (
    .clk           (clk),
    .rst           (rst),
    .coin          (coin),
    .sel_valid     (sel_valid),
    .sel_item      (sel_item),
    .cancel        (cancel),
    .refill_valid  (refill_valid),
    .refill_item   (refill_item),
    .despatch      (despatch),
    .despatch_item (despatch_item),
    .sel_nack      (sel_nack),
    .coin_reject   (coin_reject),
    .change_valid  (change_valid),
    .change_coin   (change_coin),
    .credit        (credit),
    .sold_out      (sold_out),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    coin = 2'b00; sel_valid = 1'b0; sel_item = 2'd0;
    cancel = 1'b0; refill_valid = 1'b0; refill_item = 2'd0;
  endtask

  task automatic put_coin(input logic [1:0] c);
    coin = c;
    step();
    coin = 2'b00;
  endtask

  // Scoreboard: despatch and change events are popped as the DUT produces them.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (despatch === 1'b1) begin
        tests++;
        assert (exp_desp.size() != 0) else begin
          fails++;
          $error("FAIL despatch_unexpected observed=%0d expected=none", despatch_item);
        end
        if (exp_desp.size() != 0) check("despatch_item", 32'(despatch_item), 32'(exp_desp.pop_front()));
      end
      if (change_valid === 1'b1) begin
        tests++;
        assert (exp_change.size() != 0) else begin
          fails++;
          $error("FAIL change_unexpected observed=%0b expected=none", change_coin);
        end
        if (exp_change.size() != 0) check("change_coin", 32'(change_coin), 32'(exp_change.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle_inputs();
    step(); step();
    check("rst_despatch", 32'(despatch), 0);
    check("rst_credit", 32'(credit), 0);
    check("rst_sold_out", 32'(sold_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_change_valid", 32'(change_valid), 0);
    rst = 1'b1;
    step();

    // Exact-price purchase of item0
    put_coin(2'b01);
    check("credit_5", 32'(credit), 1);
    put_coin(2'b10);
    check("credit_15", 32'(credit), 3);
    sel_valid = 1'b1; sel_item = 2'd0;
    exp_desp.push_back(2'd0);
    step();
    sel_valid = 1'b0;
    check("vend_despatch", 32'(despatch), 1);
    check("vend_busy", 32'(busy), 1);
    step();
    check("vend1_despatch_off", 32'(despatch), 0);
    check("vend1_credit", 32'(credit), 0);
    check("vend1_no_change", 32'(change_valid), 0);
    check("vend1_idle", 32'(busy), 0);

    // Purchase with change 10 then 5
    put_coin(2'b11);
    put_coin(2'b10);
    check("credit_30", 32'(credit), 6);
    sel_valid = 1'b1; sel_item = 2'd0;
    exp_desp.push_back(2'd0);
    exp_change.push_back(2'b10);
    exp_change.push_back(2'b01);
    step();
    sel_valid = 1'b0;
    step();
    check("chg1_valid", 32'(change_valid), 1);
    check("chg1_credit", 32'(credit), 3);
    step();
    check("chg2_coin", 32'(change_coin), 32'(2'b01));
    step();
    check("chg_done_credit", 32'(credit), 0);
    check("chg_done_valid", 32'(change_valid), 0);
    check("sold_out_item0", 32'(sold_out), 32'(4'b0001));

    // Insufficient credit
    put_coin(2'b10);
    sel_valid = 1'b1; sel_item = 2'd2;
    step();
    sel_valid = 1'b0;
    check("nack_price", 32'(sel_nack), 1);
    check("nack_credit", 32'(credit), 2);
    check("nack_no_despatch", 32'(despatch), 0);
    step();
    check("nack_pulse_off", 32'(sel_nack), 0);

    // Sold-out refusal, refill, then purchase
    put_coin(2'b11);
    sel_valid = 1'b1; sel_item = 2'd0;
    step();
    sel_valid = 1'b0;
    check("nack_stock", 32'(sel_nack), 1);
    check("nack_stock_credit", 32'(credit), 6);
    refill_valid = 1'b1; refill_item = 2'd0;
    step();
    refill_valid = 1'b0;
    check("refill_sold_out", 32'(sold_out), 0);
    sel_valid = 1'b1; sel_item = 2'd0;
    exp_desp.push_back(2'd0);
    exp_change.push_back(2'b10);
    exp_change.push_back(2'b01);
    step();
    sel_valid = 1'b0;
    check("refill_vend", 32'(despatch), 1);
    step(); step(); step();
    check("refill_vend_credit", 32'(credit), 0);
    check("refill_vend_sold_out", 32'(sold_out), 32'(4'b0001));

    // Cancel beats selection; coin during change is rejected
    put_coin(2'b11); put_coin(2'b10); put_coin(2'b01);
    check("credit_35", 32'(credit), 7);
    cancel = 1'b1; sel_valid = 1'b1; sel_item = 2'd1;
    exp_change.push_back(2'b11);
    exp_change.push_back(2'b10);
    exp_change.push_back(2'b01);
    step();
    cancel = 1'b0; sel_valid = 1'b0;
    check("cancel_no_despatch", 32'(despatch), 0);
    check("cancel_change_coin", 32'(change_coin), 32'(2'b11));
    coin = 2'b01;
    step();
    coin = 2'b00;
    check("change_coin_reject", 32'(coin_reject), 1);
    check("change_reject_credit", 32'(credit), 3);
    step(); step();
    check("cancel_idle_credit", 32'(credit), 0);
    check("cancel_idle_busy", 32'(busy), 0);

    // Credit cap boundary
    put_coin(2'b11); put_coin(2'b11); put_coin(2'b11); put_coin(2'b11);
    put_coin(2'b10); put_coin(2'b01);
    check("credit_95", 32'(credit), 19);
    put_coin(2'b10);
    check("cap_reject", 32'(coin_reject), 1);
    check("cap_credit", 32'(credit), 19);
    put_coin(2'b01);
    check("cap_exact_accept", 32'(coin_reject), 0);
    check("cap_exact_credit", 32'(credit), 20);
    cancel = 1'b1;
    repeat (5) exp_change.push_back(2'b11);
    step();
    cancel = 1'b0;
    repeat (5) step();
    check("cap_change_done", 32'(credit), 0);

    // Reset in the middle of change
    put_coin(2'b11); put_coin(2'b10); put_coin(2'b01);
    cancel = 1'b1;
    exp_change.push_back(2'b11);
    step();
    cancel = 1'b0;
    step();
    rst = 1'b0;
    #1;
    check("midrst_change_valid", 32'(change_valid), 0);
    check("midrst_change_coin", 32'(change_coin), 0);
    check("midrst_credit", 32'(credit), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_sold_out", 32'(sold_out), 0);
    step(); step();
    rst = 1'b1;
    step();
    put_coin(2'b11);
    sel_valid = 1'b1; sel_item = 2'd0;
    exp_desp.push_back(2'd0);
    exp_change.push_back(2'b01);
    step();
    sel_valid = 1'b0;
    step(); step();
    check("post_rst_stock", 32'(sold_out), 0);
    check("post_rst_credit", 32'(credit), 0);
    step();

    check("desp_queue_empty", 32'(exp_desp.size()), 0);
    check("change_queue_empty", 32'(exp_change.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
